// File: rtl/freq_step_pwm.sv
// Period stepper and complementary gate driver for the resonant stage.
// Define DEADTIME_EN to insert DT clk cycles of dead time before each gate pulse.
module freq_step_pwm #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PER_INIT = 1250,
  parameter int unsigned PER_MIN  = 1000,
  parameter int unsigned PER_MAX  = 1600,
  parameter int unsigned STEP     = 4,
  parameter int unsigned DT       = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             freq_ready,
  input  logic             freq_set_up_down,
  input  logic             freq_opt,
  output logic             gate_hi,
  output logic             gate_lo,
  output logic [CNT_W-1:0] period,
  output logic             period_update,
  output logic             locked,
  output logic             limit_hit
);

  localparam logic [CNT_W-1:0] PerInitW = CNT_W'(PER_INIT);
  localparam logic [CNT_W:0]   PerMinW  = (CNT_W + 1)'(PER_MIN);
  localparam logic [CNT_W:0]   PerMaxW  = (CNT_W + 1)'(PER_MAX);
  localparam logic [CNT_W:0]   StepW    = (CNT_W + 1)'(STEP);

`ifdef DEADTIME_EN
  localparam logic [CNT_W-1:0] DtW = CNT_W'(DT);
  if (2 * DT >= PER_MIN) begin : g_dt_check
    $error("freq_step_pwm: 2*DT must be below PER_MIN");
  end
`endif

  typedef enum logic [1:0] {StIdle, StSweep, StLocked} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             gate_hi_q, gate_hi_d;
  logic             gate_lo_q, gate_lo_d;
  logic             limit_q, limit_d;
  logic             running, wrap, step;
  logic [CNT_W:0]   step_sum;
  logic [CNT_W-1:0] half;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (en) state_d = StSweep;
      StSweep:  if (freq_opt) state_d = StLocked;
      StLocked: state_d = StLocked;
      default:  state_d = StIdle;
    endcase
    if (!en) state_d = StIdle;
  end

  assign running = en && (state_q != StIdle);
  assign wrap    = running && (cnt_q == period_q - 1'b1);
  // freq_opt wins over a coincident freq_ready
  assign step    = en && (state_q == StSweep) && freq_ready && !freq_opt;
  assign half    = period_q >> 1;

  always_comb begin
    pending_d = pending_q;
    limit_d   = limit_q;
    step_sum  = freq_set_up_down ? ({1'b0, pending_q} - StepW) : ({1'b0, pending_q} + StepW);
    if (step) begin
      if (freq_set_up_down && (step_sum[CNT_W] || step_sum < PerMinW)) begin
        pending_d = PerMinW[CNT_W-1:0];
        limit_d   = 1'b1;
      end else if (!freq_set_up_down && step_sum > PerMaxW) begin
        pending_d = PerMaxW[CNT_W-1:0];
        limit_d   = 1'b1;
      end else begin
        pending_d = step_sum[CNT_W-1:0];
      end
    end
    if (!en) limit_d = 1'b0;
  end

  always_comb begin
    cnt_d         = '0;
    period_d      = period_q;
    period_update = 1'b0;
    if (running && !wrap) cnt_d = cnt_q + 1'b1;
    if (wrap && (pending_q != period_q)) begin
      period_d      = pending_q;
      period_update = 1'b1;
    end
  end

  always_comb begin
`ifdef DEADTIME_EN
    gate_hi_d = running && (cnt_q >= DtW) && (cnt_q < half);
    gate_lo_d = running && (cnt_q >= half + DtW) && (cnt_q < period_q);
`else
    gate_hi_d = running && (cnt_q < half);
    gate_lo_d = running && !(cnt_q < half);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      period_q  <= PerInitW;
      pending_q <= PerInitW;
      gate_hi_q <= 1'b0;
      gate_lo_q <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      gate_hi_q <= gate_hi_d;
      gate_lo_q <= gate_lo_d;
      limit_q   <= limit_d;
    end
  end

  assign gate_hi   = gate_hi_q;
  assign gate_lo   = gate_lo_q;
  assign period    = period_q;
  assign locked    = (state_q == StLocked);
  assign limit_hit = limit_q;

endmodule

// File: tb/tb_freq_step_pwm.sv
// Directed bench for freq_step_pwm; expectations adapt to DEADTIME_EN.
module tb_freq_step_pwm;

`ifdef DEADTIME_EN
  localparam int DT_E = 25;
`else
  localparam int DT_E = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, freq_ready, freq_set_up_down, freq_opt;
  logic        gate_hi, gate_lo, period_update, locked, limit_hit;
  logic [15:0] period;

  int n_cmp = 0;
  int n_bad = 0;

  freq_step_pwm dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .freq_ready       (freq_ready),
    .freq_set_up_down (freq_set_up_down),
    .freq_opt         (freq_opt),
    .gate_hi          (gate_hi),
    .gate_lo          (gate_lo),
    .period           (period),
    .period_update    (period_update),
    .locked           (locked),
    .limit_hit        (limit_hit)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Length of one full gate_hi pulse and of the gate_lo pulse that follows it.
  task automatic measure(output int hi, output int lo, output int both);
    int guard;
    hi = 0; lo = 0; both = 0; guard = 0;
    while (gate_hi === 1'b1 && guard < 4000) begin cyc(1); guard++; end
    while (gate_hi !== 1'b1 && guard < 8000) begin cyc(1); guard++; end
    while (gate_hi === 1'b1 && guard < 12000) begin
      hi++;
      if (gate_lo === 1'b1) both++;
      cyc(1); guard++;
    end
    while (gate_hi !== 1'b1 && guard < 16000) begin
      if (gate_lo === 1'b1) lo++;
      cyc(1); guard++;
    end
  endtask

  initial begin
    int first_hi, last_hi, first_lo, last_lo, both_n, none_n, pu_n, pu_at, per_at;
    int hi_len, lo_len, guard;

    rst = 1'b1; en = 1'b0; freq_ready = 1'b0; freq_set_up_down = 1'b0; freq_opt = 1'b0;
    @(negedge clk);
    check("rst_gate_hi", gate_hi, 0);
    check("rst_gate_lo", gate_lo, 0);
    check("rst_period", period, 1250);
    check("rst_update", period_update, 0);
    check("rst_locked", locked, 0);
    check("rst_limit", limit_hit, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: first PWM cycle at the reset period, cnt tracked by loop index
    en = 1'b1;
    cyc(1);
    check("t1_idle_gate", gate_hi, 0);
    first_hi = -1; last_hi = -1; first_lo = -1; last_lo = -1;
    both_n = 0; none_n = 0; pu_n = 0;
    for (int i = 0; i < 1250; i++) begin
      cyc(1);
      if (gate_hi === 1'b1) begin
        if (first_hi < 0) first_hi = i;
        last_hi = i;
      end
      if (gate_lo === 1'b1) begin
        if (first_lo < 0) first_lo = i;
        last_lo = i;
      end
      if (gate_hi === 1'b1 && gate_lo === 1'b1) both_n++;
      if (gate_hi !== 1'b1 && gate_lo !== 1'b1) none_n++;
      if (period_update === 1'b1) pu_n++;
    end
    check("t1_first_hi", first_hi, DT_E);
    check("t1_last_hi", last_hi, 624);
    check("t1_first_lo", first_lo, 625 + DT_E);
    check("t1_last_lo", last_lo, 1249);
    check("t1_both", both_n, 0);
    check("t1_none", none_n, 2 * DT_E);
    check("t1_no_update", pu_n, 0);

    // 2: one up-step at cnt=100; takes effect only at the wrap
    cyc(100);
    freq_ready = 1'b1; freq_set_up_down = 1'b1;
    cyc(1);
    freq_ready = 1'b0;
    check("t2_hold", period, 1250);
    pu_n = 0; pu_at = -1; per_at = -1;
    for (int j = 0; j < 1300; j++) begin
      if (period_update === 1'b1) begin
        pu_n++; pu_at = j; per_at = period;
      end
      cyc(1);
    end
    check("t2_update_count", pu_n, 1);
    check("t2_update_at_wrap", pu_at, 1148);
    check("t2_period_at_update", per_at, 1250);
    check("t2_period_new", period, 1246);
    measure(hi_len, lo_len, both_n);
    check("t2_hi_len", hi_len, 623 - DT_E);
    check("t2_lo_len", lo_len, 623 - DT_E);
    check("t2_both", both_n, 0);

    // 3: 88 down-steps reach 1598, the 89th clamps at PER_MAX
    freq_set_up_down = 1'b0; freq_ready = 1'b1;
    cyc(88);
    freq_ready = 1'b0;
    check("t3_no_clamp", limit_hit, 0);
    freq_ready = 1'b1;
    cyc(1);
    freq_ready = 1'b0;
    check("t3_limit", limit_hit, 1);
    cyc(3300);
    check("t3_period_max", period, 1600);
    freq_ready = 1'b1;
    cyc(3);
    freq_ready = 1'b0;
    pu_n = 0;
    for (int j = 0; j < 3300; j++) begin
      if (period_update === 1'b1) pu_n++;
      cyc(1);
    end
    check("t3_no_update", pu_n, 0);
    check("t3_period_kept", period, 1600);
    check("t3_limit_sticky", limit_hit, 1);

    // en=0 clears gates and flags but keeps the period
    en = 1'b0;
    cyc(1);
    check("off_gate_hi", gate_hi, 0);
    check("off_gate_lo", gate_lo, 0);
    check("off_limit", limit_hit, 0);
    check("off_period", period, 1600);

    // 5: asynchronous reset in the middle of a gate_hi pulse
    en = 1'b1;
    guard = 0;
    while (gate_hi !== 1'b1 && guard < 4000) begin cyc(1); guard++; end
    check("t5_hi_seen", gate_hi, 1);
    #3 rst = 1'b1;
    #1;
    check("t5_async_hi", gate_hi, 0);
    check("t5_async_lo", gate_lo, 0);
    @(negedge clk);
    rst = 1'b0;
    check("t5_period", period, 1250);
    check("t5_locked", locked, 0);

    // 4: freq_opt beats a coincident freq_ready, then steps are ignored
    cyc(10);
    freq_opt = 1'b1; freq_ready = 1'b1; freq_set_up_down = 1'b1;
    cyc(1);
    freq_ready = 1'b0; freq_opt = 1'b0;
    check("t4_locked", locked, 1);
    freq_ready = 1'b1;
    cyc(3);
    freq_ready = 1'b0;
    pu_n = 0;
    for (int j = 0; j < 1400; j++) begin
      if (period_update === 1'b1) pu_n++;
      cyc(1);
    end
    check("t4_no_update", pu_n, 0);
    check("t4_period", period, 1250);
    check("t4_still_locked", locked, 1);
    en = 1'b0;
    cyc(1);
    check("t4_unlock", locked, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
